// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one combinational ALU, with a one-deep registered
// response that carries the owning requester's ID and its own valid/ready handshake.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter int ROUND_ROBIN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_switch,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_switch,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_operation,
    output logic             alu_switch,
    input  logic [WIDTH-1:0] alu_o,
    input  logic [3:0]       alu_flags,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_o,
    output logic [3:0]       rsp_flags,

    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and ready never looks at alu_*.

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_o;
    logic [3:0]       r_rsp_flags;
    logic [CNT_W-1:0] r_grant0_cnt;
    logic [CNT_W-1:0] r_grant1_cnt;
    logic             r_last_grant;

    logic             w_slot_free;
    logic             w_grant_any;
    logic             w_grant_sel;

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign w_grant_any = !rst && w_slot_free && (req0_valid || req1_valid);

    // Under contention round-robin picks the port that did not win last time.
    always_comb begin
        w_grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            if (ROUND_ROBIN != 0) begin
                w_grant_sel = ~r_last_grant;
            end else begin
                w_grant_sel = 1'b0;
            end
        end else if (req1_valid) begin
            w_grant_sel = 1'b1;
        end
    end

    assign req0_ready = w_grant_any && !w_grant_sel;
    assign req1_ready = w_grant_any &&  w_grant_sel;

    always_comb begin
        alu_a         = '0;
        alu_b         = '0;
        alu_operation = '0;
        alu_switch    = 1'b0;
        if (w_grant_any) begin
            if (w_grant_sel) begin
                alu_a         = req1_a;
                alu_b         = req1_b;
                alu_operation = req1_op;
                alu_switch    = req1_switch;
            end else begin
                alu_a         = req0_a;
                alu_b         = req0_b;
                alu_operation = req0_op;
                alu_switch    = req0_switch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_o      <= '0;
            r_rsp_flags  <= '0;
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
            r_last_grant <= 1'b1;
        end else if (w_grant_any) begin
            // A grant while the old response drains replaces it with no bubble.
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= w_grant_sel;
            r_rsp_o      <= alu_o;
            r_rsp_flags  <= alu_flags;
            r_last_grant <= w_grant_sel;
            if (w_grant_sel) begin
                r_grant1_cnt <= r_grant1_cnt + CNT_ONE;
            end else begin
                r_grant0_cnt <= r_grant0_cnt + CNT_ONE;
            end
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_o      = r_rsp_o;
    assign rsp_flags  = r_rsp_flags;
    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;

endmodule
